// File: rtl/byte_frame_checker.sv
// byte_frame_checker: delimits demodulated byte frames, checks CRC-16-CCITT, buffers frame bytes in a FIFO.
// Latency: a byte is readable 1 cycle after acceptance; frame status (frameDone pulse) 1 cycle after the closing byte.
// Backpressure: stopIn is registered and high while free entries <= SLACK; a byte arriving to a full FIFO is dropped and sets overflow.
//
// Ports:
//   clk, reset                         - clock, synchronous active-high reset
//   pushByte, Byte, Sync, lastByte     - byte stream from the demodulator
//   stopIn                             - flow control back to the demodulator
//   popOut, dataOut, outValid          - consumer side of the byte FIFO
//   frameDone, crcOk, frameAbort,
//   frameLen, overflow                 - per-frame status (held until the next frameDone) and sticky overflow
module byte_frame_checker #(
  parameter int DEPTH = 16,
  parameter int SLACK = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pushByte,
  input  logic [7:0] Byte,
  input  logic       Sync,
  input  logic       lastByte,
  output logic       stopIn,
  input  logic       popOut,
  output logic [7:0] dataOut,
  output logic       outValid,
  output logic       frameDone,
  output logic       crcOk,
  output logic       frameAbort,
  output logic [7:0] frameLen,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] SLACK_CNT = CW'(SLACK);

  typedef enum logic {
    ST_IDLE,
    ST_RECV
  } state_t;

  // One byte of CRC-16-CCITT (poly 0x1021), MSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  state_t          state_q, state_d;
  logic [15:0]     crc_q, crc_d;
  logic [7:0]      len_q, len_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            ok_q, ok_d;
  logic            abort_q, abort_d;
  logic [7:0]      flen_q, flen_d;
  logic            ovf_q, ovf_d;
  logic            stop_q, stop_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [DEPTH];

  logic            pop_ok;
  logic            room;
  logic            take;
  logic            wr_en;
  logic            err_nxt;
  logic [15:0]     crc_next;
  logic [15:0]     crc_init;
  logic [7:0]      len_inc;

  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign pop_ok = popOut && (count_q != '0);
  assign room   = (count_q != FULL_CNT) || pop_ok;

  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    len_d    = len_q;
    err_d    = err_q;
    done_d   = 1'b0;
    ok_d     = ok_q;
    abort_d  = abort_q;
    flen_d   = flen_q;
    ovf_d    = ovf_q;
    take     = 1'b0;
    err_nxt  = err_q;
    crc_next = crc_step(crc_q, Byte);
    crc_init = crc_step(16'hFFFF, Byte);
    len_inc  = (len_q == 8'hFF) ? 8'hFF : len_q + 8'd1;

    unique case (state_q)
      ST_IDLE: begin
        if (pushByte && Sync) begin
          take  = 1'b1;
          crc_d = crc_init;
          len_d = 8'd1;
          err_d = !room;
          if (lastByte) begin
            // A lone byte cannot hold a CRC: report it as a short, failed frame.
            done_d  = 1'b1;
            ok_d    = 1'b0;
            abort_d = !room;
            flen_d  = 8'd1;
          end else begin
            state_d = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (pushByte && Sync) begin
          // Restart: report the interrupted frame, then begin the new one with this byte.
          take    = 1'b1;
          done_d  = 1'b1;
          ok_d    = 1'b0;
          abort_d = 1'b1;
          flen_d  = len_q;
          crc_d   = crc_init;
          len_d   = 8'd1;
          err_d   = !room;
          // The status slot this cycle belongs to the aborted frame, so a
          // Sync+lastByte restart closes silently.
          state_d = lastByte ? ST_IDLE : ST_RECV;
        end else if (pushByte) begin
          take    = 1'b1;
          err_nxt = err_q | !room;
          crc_d   = crc_next;
          len_d   = len_inc;
          err_d   = err_nxt;
          if (lastByte) begin
            done_d  = 1'b1;
            ok_d    = (crc_next == 16'h0000) && (len_inc >= 8'd3) && !err_nxt;
            abort_d = err_nxt;
            flen_d  = len_inc;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    wr_en = take && room;
    if (take && !room) begin
      ovf_d = 1'b1;
    end

    wr_ptr_d = wr_en  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(wr_en) - CW'(pop_ok);
    stop_d   = (FULL_CNT - count_d) <= SLACK_CNT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      crc_q    <= 16'h0000;
      len_q    <= 8'd0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
      abort_q  <= 1'b0;
      flen_q   <= 8'd0;
      ovf_q    <= 1'b0;
      stop_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      len_q    <= len_d;
      err_q    <= err_d;
      done_q   <= done_d;
      ok_q     <= ok_d;
      abort_q  <= abort_d;
      flen_q   <= flen_d;
      ovf_q    <= ovf_d;
      stop_q   <= stop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once the count covers them.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem_q[wr_ptr_q] <= Byte;
    end
  end

  assign outValid   = (count_q != '0);
  assign dataOut    = outValid ? mem_q[rd_ptr_q] : 8'h00;
  assign stopIn     = stop_q;
  assign frameDone  = done_q;
  assign crcOk      = ok_q;
  assign frameAbort = abort_q;
  assign frameLen   = flen_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_byte_frame_checker.sv
module tb_byte_frame_checker;
  localparam int DEPTH = 16;
  localparam int SLACK = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pushByte = 1'b0;
  logic [7:0] Byte = 8'h00;
  logic       Sync = 1'b0;
  logic       lastByte = 1'b0;
  logic       popOut = 1'b0;
  logic       stopIn;
  logic [7:0] dataOut;
  logic       outValid;
  logic       frameDone;
  logic       crcOk;
  logic       frameAbort;
  logic [7:0] frameLen;
  logic       overflow;

  byte_frame_checker #(.DEPTH(DEPTH), .SLACK(SLACK)) dut (
    .clk(clk), .reset(reset), .pushByte(pushByte), .Byte(Byte), .Sync(Sync),
    .lastByte(lastByte), .stopIn(stopIn), .popOut(popOut), .dataOut(dataOut),
    .outValid(outValid), .frameDone(frameDone), .crcOk(crcOk), .frameAbort(frameAbort),
    .frameLen(frameLen), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0] mq[$];       // FIFO contents
  logic [7:0] mframe[$];   // bytes of the open frame
  bit m_in, m_err, m_done, m_ok, m_abort, m_ovf, m_stop;
  int m_flen;

  // Bit-serial CRC over a whole message.
  function automatic logic [15:0] crc_of(input logic [7:0] d[$]);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    foreach (d[i]) begin
      for (int k = 7; k >= 0; k--) begin
        fb = c[15] ^ d[i][k];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  function automatic int sat(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  function automatic void m_close(input bit ok, input bit ab, input int len);
    m_done = 1; m_ok = ok; m_abort = ab; m_flen = len;
  endfunction

  function automatic void model_reset();
    mq.delete(); mframe.delete();
    m_in = 0; m_err = 0; m_done = 0; m_ok = 0; m_abort = 0; m_ovf = 0; m_stop = 0; m_flen = 0;
  endfunction

  function automatic void model_step(input bit p, input bit s, input bit l, input logic [7:0] b, input bit po);
    bit pop_ok, room, was_in;
    pop_ok = po && (mq.size() > 0);
    room   = (mq.size() < DEPTH) || pop_ok;
    m_done = 0;
    if (pop_ok) void'(mq.pop_front());
    if (p && (s || m_in)) begin
      was_in = m_in;
      if (s) begin
        if (was_in) m_close(0, 1, sat(mframe.size()));
        mframe.delete(); m_err = 0; m_in = 1;
      end
      mframe.push_back(b);
      if (room) mq.push_back(b);
      else begin m_err = 1; m_ovf = 1; end
      if (l) begin
        if (!s) m_close((crc_of(mframe) == 16'h0000) && (mframe.size() >= 3) && !m_err, m_err, sat(mframe.size()));
        else if (!was_in) m_close(0, m_err, 1);
        m_in = 0;
      end
    end
    m_stop = (DEPTH - mq.size()) <= SLACK;
  endfunction

  task automatic check_model();
    chk("model.stopIn", stopIn, m_stop);
    chk("model.outValid", outValid, mq.size() > 0);
    if (mq.size() > 0) chk("model.dataOut", dataOut, mq[0]);
    chk("model.frameDone", frameDone, m_done);
    chk("model.crcOk", crcOk, m_ok);
    chk("model.frameAbort", frameAbort, m_abort);
    chk("model.frameLen", frameLen, m_flen);
    chk("model.overflow", overflow, m_ovf);
  endtask

  // One clock: drive inputs, advance model, sample 1 time unit after the edge.
  task automatic step(input bit p, input bit s, input bit l, input logic [7:0] b, input bit po);
    pushByte = p; Sync = s; lastByte = l; Byte = b; popOut = po;
    @(posedge clk);
    model_step(p, s, l, b, po);
    #1;
    check_model();
    pushByte = 0; Sync = 0; lastByte = 0; popOut = 0;
  endtask

  task automatic do_reset();
    reset = 1; pushByte = 0; Sync = 0; lastByte = 0; popOut = 0;
    @(posedge clk);
    model_reset();
    #1;
    reset = 0;
    chk("rst.stopIn", stopIn, 0);
    chk("rst.outValid", outValid, 0);
    chk("rst.dataOut", dataOut, 0);
    chk("rst.frameDone", frameDone, 0);
    chk("rst.crcOk", crcOk, 0);
    chk("rst.frameAbort", frameAbort, 0);
    chk("rst.frameLen", frameLen, 0);
    chk("rst.overflow", overflow, 0);
  endtask

  task automatic chk_status(input string tag, input bit ok, input bit ab, input int len);
    chk({tag, ".frameDone"}, frameDone, 1);
    chk({tag, ".crcOk"}, crcOk, ok);
    chk({tag, ".frameAbort"}, frameAbort, ab);
    chk({tag, ".frameLen"}, frameLen, len);
  endtask

  // ---------------- frame-level vector table ----------------
  typedef struct {
    logic [7:0] data [11];
    int         n;
    bit         ok;
    bit         ab;
    int         len;
  } vec_t;

  vec_t tbl[5];
  logic [7:0] good[11];

  initial begin
    good = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
    tbl[0].data = good;                                     tbl[0].n = 11; tbl[0].ok = 1; tbl[0].ab = 0; tbl[0].len = 11;
    tbl[1].data = good; tbl[1].data[10] = 8'hB0;            tbl[1].n = 11; tbl[1].ok = 0; tbl[1].ab = 0; tbl[1].len = 11;
    tbl[2].data = '{8'h00, 8'hE1, 8'hF0, 0, 0, 0, 0, 0, 0, 0, 0}; tbl[2].n = 3; tbl[2].ok = 1; tbl[2].ab = 0; tbl[2].len = 3;
    tbl[3].data = '{8'hFF, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 0};     tbl[3].n = 2; tbl[3].ok = 0; tbl[3].ab = 0; tbl[3].len = 2;
    tbl[4].data = '{8'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};         tbl[4].n = 1; tbl[4].ok = 0; tbl[4].ab = 0; tbl[4].len = 1;

    model_reset();
    do_reset();

    // Table: send each frame, check status, drain and check byte order.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < tbl[v].n; i++)
        step(1, i == 0, i == tbl[v].n - 1, tbl[v].data[i], 0);
      chk_status($sformatf("tbl%0d", v), tbl[v].ok, tbl[v].ab, tbl[v].len);
      for (int i = 0; i < tbl[v].n; i++) begin
        chk($sformatf("tbl%0d.byte%0d", v, i), dataOut, tbl[v].data[i]);
        step(0, 0, 0, 8'h00, 1);
      end
      chk($sformatf("tbl%0d.empty", v), outValid, 0);
    end

    // Abort: 3 bytes, then a restart carrying the good frame.
    step(1, 1, 0, 8'h31, 0);
    step(1, 0, 0, 8'h32, 0);
    step(1, 0, 0, 8'h33, 0);
    step(1, 1, 0, good[0], 0);
    chk_status("abort1", 0, 1, 3);
    for (int i = 1; i < 11; i++) step(1, 0, i == 10, good[i], 0);
    chk_status("abort2", 1, 0, 11);
    for (int i = 0; i < 14; i++) step(0, 0, 0, 8'h00, 1);

    // Bytes without Sync in IDLE are discarded.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'hA0 + 8'(i), 0);
    chk("idle.outValid", outValid, 0);

    // Backpressure and overflow with no pops.
    for (int i = 0; i < 17; i++) begin
      step(1, i == 0, i == 16, 8'h40 + 8'(i), 0);
      if (i == 10) chk("bp.stopIn11", stopIn, 0);
      if (i == 11) chk("bp.stopIn12", stopIn, 1);
      if (i == 15) chk("bp.ovf16", overflow, 0);
    end
    chk("bp.overflow", overflow, 1);
    chk_status("bp", 0, 1, 17);
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("bp.byte%0d", j), dataOut, 8'h40 + 8'(j));
      step(0, 0, 0, 8'h00, 1);
    end
    chk("bp.empty", outValid, 0);

    // Push and pop together at count 5 keeps the count at 5.
    for (int i = 0; i < 5; i++) step(1, i == 0, 0, 8'h60 + 8'(i), 0);
    step(1, 0, 0, 8'h65, 1);
    begin
      int n = 0;
      while (outValid && n < 20) begin
        step(0, 0, 0, 8'h00, 1);
        n++;
      end
      chk("pp.count", n, 5);
    end

    // Reset mid-frame, then a good frame.
    for (int i = 0; i < 4; i++) step(1, i == 0, 0, 8'h70 + 8'(i), 0);
    do_reset();
    for (int i = 0; i < 11; i++) step(1, i == 0, i == 10, good[i], 0);
    chk_status("postrst", 1, 0, 11);

    // Randomized traffic against the model, with occasional correct CRC tails.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit p, s, l, po;
      logic [7:0] b;
      logic [15:0] c;
      po = (cyc < 1500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else if (m_in && $urandom_range(0, 11) == 0) begin
        c = crc_of(mframe);
        step(1, 0, 0, c[15:8], po);
        step(1, 0, 1, c[7:0], $urandom_range(0, 1) == 1);
      end else begin
        p = $urandom_range(0, 1) == 1;
        s = p && ($urandom_range(0, 7) == 0);
        l = p && ($urandom_range(0, 9) == 0);
        b = 8'($urandom);
        step(p, s, l, b, po);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/byte_frame_checker.md
# byte_frame_checker

Downstream of the Costas demodulator's byte FIFO. Accepts the demodulated byte stream (`pushByte`/`Byte`/`Sync`/`lastByte`), delimits frames, and checks each frame's CRC-16-CCITT. It buffers every accepted byte in an internal FIFO for the host-side consumer and drives `stopIn` back to the demodulator as flow control. At the end of each frame it reports pass/fail status and the frame length.

## Interface
Parameters:
- `DEPTH`, 16: internal FIFO depth in bytes; power of two, at least 8.
- `SLACK`, 4: `stopIn` asserts when free entries ≤ `SLACK`.

Ports:
- `clk` in 1: single clock; every register is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `pushByte` in 1: byte valid from the demodulator, one cycle per byte.
- `Byte` in 8: data byte, sampled when `pushByte`=1.
- `Sync` in 1: qualifies the first byte of a frame; valid only with `pushByte`.
- `lastByte` in 1: qualifies the final byte of a frame; valid only with `pushByte`.
- `stopIn` out 1: backpressure to the demodulator.
- `popOut` in 1: consumer pop request.
- `dataOut` out 8: FIFO head byte, valid while `outValid`=1.
- `outValid` out 1: FIFO not empty.
- `frameDone` out 1: one-cycle pulse at frame end.
- `crcOk` out 1: CRC result, held until the next `frameDone`.
- `frameAbort` out 1: the frame ended abnormally; held with `crcOk`.
- `frameLen` out 8: bytes in the frame, CRC bytes included; saturates at 255; held.
- `overflow` out 1: sticky; set on a byte dropped because the FIFO was full; cleared only by reset.

## Operation
- A frame is the payload followed by a 2-byte CRC, MSB first.
- CRC-16-CCITT: polynomial 0x1021, init 0xFFFF, non-reflected, no final XOR.
- The checker runs the CRC over every byte of the frame, CRC bytes included. The frame passes when the residue is 0x0000 and `frameLen` ≥ 3.
- The CRC is processed 8 bits per accepted byte, combinationally, in a single cycle.
- State machine:
  - IDLE: `pushByte`&`Sync` → load CRC with init and the byte, set len=1, go to RECV.
    - If `lastByte` is also set, close immediately as a 1-byte frame: `crcOk`=0, `frameAbort`=0.
    - `pushByte` without `Sync` → byte discarded, not written to the FIFO.
  - RECV: each `pushByte` → write the byte, update the CRC, len+1 (saturating). `lastByte` → close the frame and go to IDLE.
  - RECV with `pushByte`&`Sync`: abort the current frame and start a new one with this byte.
    - `frameDone` pulses with `frameAbort`=1, `crcOk`=0, `frameLen` = old length.
- Every frame byte is written to the FIFO, including CRC bytes and bytes of frames that later fail or abort. The consumer uses the status outputs to decide what to discard.
- FIFO full and `pushByte`=1:
  - the byte is dropped and `overflow` is set;
  - the CRC and len are still updated;
  - the frame is forced to fail (`crcOk`=0, `frameAbort`=1 at close).
- A push and a pop in the same cycle are both honoured, and the count is unchanged. A push into an empty FIFO is not bypassed to the output.
- `popOut` while `outValid`=0 is ignored.
- Pointers wrap modulo `DEPTH`. The count is `log2(DEPTH)+1` bits.
- `reset` at any point, including mid-frame, clears:
  - the FIFO pointers and count;
  - the state, which returns to IDLE;
  - the CRC, len, and all outputs.

## Timing
- Reset values: `stopIn`=0, `outValid`=0, `dataOut`=0, `frameDone`=0, `crcOk`=0, `frameAbort`=0, `frameLen`=0, `overflow`=0.
- A byte is accepted on the edge where `pushByte`=1.
- `outValid`/`dataOut` reflect that byte 1 cycle after the edge on which it is written.
- `frameDone` is registered. It is high for exactly the cycle after the closing byte's edge (`lastByte` or aborting `Sync`). `crcOk`, `frameAbort`, and `frameLen` update on the same edge.
- `stopIn` is registered from the post-update count. It is high from the cycle after free ≤ `SLACK` until the cycle after free > `SLACK`.
- `SLACK` covers the demodulator's in-flight bytes after `stopIn` asserts. Bytes arriving beyond that are handled by the overflow rule.
- Pop: `dataOut` advances to the next entry 1 cycle after the `popOut` edge.

## Test plan
- Good frame: push 0x31..0x39, then 0x29, 0xB1 (`Sync` on the first byte, `lastByte` on the last) → `frameDone` 1 cycle after 0xB1, `crcOk`=1, `frameAbort`=0, `frameLen`=11, 11 bytes readable in order.
- Corrupt frame: same bytes but CRC 0x29, 0xB0 → `crcOk`=0, `frameAbort`=0, `frameLen`=11.
- Abort: `Sync` on 0x31, 0x32, 0x33, then a new `Sync` on 0x31 followed by the good frame above → first `frameDone` has `frameAbort`=1, `frameLen`=3; second `frameDone` has `crcOk`=1, `frameLen`=11.
- Backpressure/overflow, `DEPTH`=16, `SLACK`=4, no pops:
  - push 12 bytes → `stopIn`=1 the cycle after the 12th byte;
  - push 5 more → the 17th byte is dropped, `overflow`=1;
  - frame close gives `crcOk`=0, `frameAbort`=1.
- Edges:
  - bytes pushed in IDLE without `Sync` → not stored, `outValid` stays 0;
  - `Sync`+`lastByte` on one byte → `frameDone` with `frameLen`=1, `crcOk`=0;
  - simultaneous push and pop at count 5 → count stays 5.
- Reset mid-frame after 4 bytes → all outputs return to reset values; a following good frame passes with `frameLen`=11.
